// File: rtl/prefetch_fetch_unit_pkg.sv
// Shared definitions for the prefetch fetch unit: FSM state encodings,
// the default reset PC and a saturating-add helper for the optional
// performance counters (IFETCH_PERF_EN).
package prefetch_fetch_unit_pkg;

   // FSM state encodings
   localparam logic [1:0] ST_FETCH     = 2'd0;  // no request outstanding
   localparam logic [1:0] ST_WAIT      = 2'd1;  // one request outstanding, keep response
   localparam logic [1:0] ST_WAIT_DROP = 2'd2;  // one request outstanding, discard response

   // Default byte address loaded on reset
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0020;

   // 32-bit add that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous reset and flush. DEPTH must be a power
// of two so the read/write pointers wrap naturally. A push into a full FIFO
// is only honoured when a pop frees an entry in the same cycle.
module sync_fifo
   import prefetch_fetch_unit_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];
   assign count   = cnt;

   // Storage write; contents need no reset because cnt gates visibility
   always_ff @(posedge clk) begin
      if (do_push && !rst && !flush) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping with reset/flush priority
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/prefetch_fetch_unit.sv
// Prefetching instruction fetch unit. Holds the PC, issues one word-aligned
// request at a time to a variable-latency instruction memory and buffers the
// returned instructions (with their PCs) in a DEPTH-entry FIFO that decode
// drains over instr_valid/instr_ready.
//
// Handshake: the FIFO head moves to decode on a rising edge where
// instr_valid && instr_ready; a request is accepted on a rising edge where
// imem_req && imem_gnt; a response is taken on any edge with imem_rvalid.
//
// Optional feature macro: IFETCH_PERF_EN adds saturating perf counters.
// fetch_state exposes the FSM encoding for observation.
module prefetch_fetch_unit
   import prefetch_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              start_up,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_base,
   input  logic [15:0]       redirect_imm16,
`ifdef IFETCH_PERF_EN
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_flushed,
   output logic [31:0]       perf_stall,
`endif
   output logic [1:0]        fetch_state
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] PC_INIT = RESET_PC & ~ADDR_W'(3);

   logic [1:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] req_pc;
   logic [ADDR_W-1:0] target;
   logic signed [17:0] off18;
   logic [ADDR_W-1:0] off_w;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [EW-1:0]     fifo_wdata;
   logic [EW-1:0]     fifo_rdata;
   logic              req_fire;

   // Branch target: base + 4 + sign-extended word offset, wrapping at ADDR_W
   assign off18  = {redirect_imm16, 2'b00};
   assign off_w  = ADDR_W'(off18);
   assign target = redirect_base + ADDR_W'(4) + off_w;

   // A request only goes out from FETCH when the FIFO has room for its
   // response; counting the in-flight word against DEPTH prevents overflow.
   assign imem_req  = !start_up && !redirect_valid && (state == ST_FETCH) &&
                      (fifo_count < CW'(DEPTH));
   assign imem_addr = pc;
   assign req_fire  = imem_req && imem_gnt;

   assign instr_valid = !start_up && !fifo_empty;
   assign {instr_pc, instr} = fifo_rdata;

   // Redirect voids both the push of a response and any pop that cycle
   assign fifo_push  = !start_up && !redirect_valid && (state == ST_WAIT) && imem_rvalid;
   assign fifo_pop   = !start_up && !redirect_valid && instr_valid && instr_ready;
   assign fifo_wdata = {req_pc, imem_rdata};

   assign fetch_state = state;

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (start_up),
      .flush (redirect_valid),
      .push  (fifo_push),
      .wdata (fifo_wdata),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Fetch FSM, PC and outstanding-request PC
   always_ff @(posedge clk) begin
      if (start_up) begin
         state  <= ST_FETCH;
         pc     <= PC_INIT;
         req_pc <= PC_INIT;
      end else if (redirect_valid) begin
         pc <= target;
         if ((state != ST_FETCH) && !imem_rvalid) begin
            state <= ST_WAIT_DROP;
         end else begin
            state <= ST_FETCH;
         end
      end else begin
         case (state)
            ST_FETCH: begin
               if (req_fire) begin
                  req_pc <= pc;
                  pc     <= pc + ADDR_W'(4);
                  state  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid) state <= ST_FETCH;
            end
            ST_WAIT_DROP: begin
               if (imem_rvalid) state <= ST_FETCH;
            end
            default: state <= ST_FETCH;
         endcase
      end
   end

`ifdef IFETCH_PERF_EN
   logic [31:0] flush_amount;

   // Entries dropped by a redirect plus a kept response that becomes stale
   assign flush_amount = 32'(fifo_count) + ((state == ST_WAIT && !imem_rvalid) ||
                                            (state == ST_WAIT && imem_rvalid) ? 32'd1 : 32'd0);

   // Saturating performance counters, cleared by start_up
   always_ff @(posedge clk) begin
      if (start_up) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
         perf_stall   <= '0;
      end else begin
         if (fifo_push) perf_fetched <= sat_add32(perf_fetched, 32'd1);
         if (redirect_valid) perf_flushed <= sat_add32(perf_flushed, flush_amount);
         if (instr_ready && !instr_valid) perf_stall <= sat_add32(perf_stall, 32'd1);
      end
   end
`endif

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Testbench for prefetch_fetch_unit: randomized memory latency, grants,
// decode back-pressure, redirects and resets, checked against a
// transaction-level model (queue of expected {pc, instr} entries plus the
// next fetch address and the fate of the outstanding request).
module tb_prefetch_fetch_unit;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0040_0020;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              start_up = 1'b1;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt = 1'b0;
   logic              imem_rvalid = 1'b0;
   logic [DATA_W-1:0] imem_rdata = '0;
   logic              instr_valid;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_ready = 1'b0;
   logic              redirect_valid = 1'b0;
   logic [ADDR_W-1:0] redirect_base = '0;
   logic [15:0]       redirect_imm16 = '0;
   logic [1:0]        fetch_state;
`ifdef IFETCH_PERF_EN
   logic [31:0]       perf_fetched, perf_flushed, perf_stall;
`endif

   prefetch_fetch_unit #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk            (clk),
      .start_up       (start_up),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .redirect_valid (redirect_valid),
      .redirect_base  (redirect_base),
      .redirect_imm16 (redirect_imm16),
`ifdef IFETCH_PERF_EN
      .perf_fetched   (perf_fetched),
      .perf_flushed   (perf_flushed),
      .perf_stall     (perf_stall),
`endif
      .fetch_state    (fetch_state)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // expected FIFO contents: {pc, instr}
   logic [ADDR_W+DATA_W-1:0] exp_q[$];
   logic [31:0] m_pc;        // next address the unit should fetch
   logic [31:0] m_req_pc;    // address of the outstanding request
   int          m_out = 0;   // 0 none, 1 response kept, 2 response dropped

   // one-shot check of the next popped PC
   bit          want_valid = 0;
   logic [31:0] want_pc;
   string       want_tag;

   // ---------------- memory model / stimulus knobs ----------------
   bit          mem_busy = 0;
   int          mem_delay = 0;
   logic [31:0] mem_addr;
   int          lat_max = 0;
   logic [31:0] salt = '0;

   int p_ready = 100, p_gnt = 100, p_redir = 0, p_redir_rv = 0, p_reset = 0;
   int force_reset = 3;
   bit force_redir = 0;
   logic [31:0] fr_base;
   logic [15:0] fr_imm;

   // ---------------- driver ----------------
   task automatic run_cycle();
      bit          exp_req, exp_valid, pop;
      logic [31:0] tgt;
      @(posedge clk);
      #1;
      start_up = (force_reset > 0) || ($urandom_range(0, 999) < p_reset);
      if (force_reset > 0) force_reset--;
      if (mem_busy && mem_delay == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_addr ^ salt;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      redirect_valid = force_redir || ($urandom_range(0, 99) < p_redir) ||
                       (imem_rvalid && $urandom_range(0, 99) < p_redir_rv);
      if (force_redir) begin
         redirect_base  = fr_base;
         redirect_imm16 = fr_imm;
      end else begin
         redirect_base  = $urandom;
         redirect_imm16 = 16'($urandom);
      end
      force_redir = 0;
      instr_ready = ($urandom_range(0, 99) < p_ready);
      imem_gnt    = ($urandom_range(0, 99) < p_gnt);

      @(negedge clk);
      // ---- compare against model ----
      exp_req   = !start_up && !redirect_valid && (m_out == 0) && (exp_q.size() < DEPTH);
      exp_valid = !start_up && (exp_q.size() > 0);
      check_eq("imem_req", imem_req, exp_req);
      if (exp_req) check_eq("imem_addr", imem_addr, m_pc);
      check_eq("instr_valid", instr_valid, exp_valid);
      if (exp_valid && instr_valid) begin
         check_eq("instr_pc", instr_pc, exp_q[0][63:32]);
         check_eq("instr", instr, exp_q[0][31:0]);
      end

      // ---- advance model to the coming edge ----
      pop = instr_valid && instr_ready && !start_up && !redirect_valid;
      if (pop && want_valid) begin
         check_eq(want_tag, instr_pc, want_pc);
         want_valid = 0;
      end
      if (start_up) begin
         m_pc = RST_PC;
         exp_q.delete();
         m_out = 0;
      end else if (redirect_valid) begin
         tgt  = redirect_base + 32'd4 + 32'($signed(redirect_imm16)) * 32'd4;
         m_pc = tgt;
         exp_q.delete();
         m_out = (m_out != 0 && !imem_rvalid) ? 2 : 0;
      end else begin
         if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
         if (imem_rvalid && m_out == 1) exp_q.push_back({m_req_pc, imem_rdata});
         if (imem_rvalid) m_out = 0;
         if (exp_req && imem_gnt) begin
            m_req_pc = m_pc;
            m_pc     = m_pc + 32'd4;
            m_out    = 1;
         end
      end

      // ---- memory model ----
      if (start_up) mem_busy = 0;
      else begin
         if (imem_rvalid) mem_busy = 0;
         else if (mem_busy) mem_delay--;
         if (imem_req && imem_gnt) begin
            mem_busy  = 1;
            mem_addr  = imem_addr;
            mem_delay = $urandom_range(0, lat_max);
         end
      end
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   task automatic wait_mem_busy(input string tag);
      int k;
      k = 0;
      while (!mem_busy && k < 20) begin
         run_cycle();
         k++;
      end
      check_eq(tag, mem_busy, 1'b1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      // reset, then 1-cycle memory returning addr as data, decode always ready
      want_valid = 1; want_pc = RST_PC; want_tag = "first_pc";
      run_n(4);
      check_eq("reset_instr_valid", instr_valid, 1'b0);
      run_n(12);

      // back-pressure: FIFO fills to DEPTH and fetching stops
      p_ready = 0;
      run_n(20);
      check_eq("stalled_req", imem_req, 1'b0);
      check_eq("stalled_valid", instr_valid, 1'b1);
      p_ready = 100;
      run_n(14);

      // redirect while a request is outstanding with a 3-cycle response
      lat_max = 2;
      p_gnt   = 100;
      wait_mem_busy("busy_before_redirect");
      fr_base = 32'h0040_0100; fr_imm = 16'hFFFE; force_redir = 1;
      want_valid = 1; want_pc = 32'h0040_00FC; want_tag = "redirect_target";
      run_n(16);
      check_eq("redirect_target_seen", want_valid, 1'b0);

      // wrap: target 0xFFFFFFFC, the following fetch goes to 0
      lat_max = 0;
      fr_base = 32'hFFFF_FFF8; fr_imm = 16'h0000; force_redir = 1;
      want_valid = 1; want_pc = 32'hFFFF_FFFC; want_tag = "wrap_target";
      run_n(10);

      // reset while waiting with buffered entries
      p_ready = 0; lat_max = 2;
      run_n(12);
      force_reset = 1;
      want_valid = 1; want_pc = RST_PC; want_tag = "restart_pc";
      run_cycle();
      check_eq("reset_req", imem_req, 1'b0);
      check_eq("reset_valid", instr_valid, 1'b0);
      p_ready = 100;
      run_n(12);

      // randomized traffic
      want_valid = 0;
      for (int phase = 0; phase < 6; phase++) begin
         p_ready    = $urandom_range(20, 100);
         p_gnt      = $urandom_range(30, 100);
         p_redir    = $urandom_range(0, 8);
         p_redir_rv = $urandom_range(0, 40);
         p_reset    = $urandom_range(0, 10);
         lat_max    = $urandom_range(0, 4);
         salt       = $urandom;
         run_n(600);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
